mac_requant_packer: RTL and testbench

MAC_REQUANT_PACKER -- requirements
Module: mac_requant_packer

---
 rtl/mac_requant_packer.sv | 166 ++++++++++++++++
 tb/tb_mac_requant_packer.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_requant_packer.sv
// Requantizes 32-bit MAC results to int8 ((acc+bias)*mult, rounded shift, saturate) and packs 4 lanes per word.
// Optional macro REQUANT_RELU_EN clamps negative results to zero before saturation.
module mac_requant_packer #(
  parameter int MULT_W  = 16,
  parameter int SHIFT_W = 5
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      acc_valid_i,
  output logic                      acc_ready_o,
  input  logic [31:0]               acc_data_i,
  input  logic                      acc_last_i,
  input  logic [31:0]               bias_i,
  input  logic signed [MULT_W-1:0]  mult_i,
  input  logic [SHIFT_W-1:0]        shift_i,
  output logic                      pk_valid_o,
  input  logic                      pk_ready_i,
  output logic [31:0]               pk_data_o,
  output logic [2:0]                pk_bytes_o,
  output logic [15:0]               sat_cnt_o,
  input  logic                      sat_clr_i
);

  localparam int P_W = 33 + MULT_W;
  localparam int R_W = P_W + 1;
  localparam logic signed [R_W-1:0] SAT_MAX = R_W'(127);

  logic                  w_en;
  logic                  w_xfer;
  logic signed [32:0]    w_sum;
  logic signed [P_W-1:0] w_prod;
  logic signed [R_W-1:0] w_round;
  logic signed [R_W-1:0] w_rnd;
  logic signed [R_W-1:0] w_y;
  logic [7:0]            w_byte;
  logic                  w_sat;
  logic                  w_laneWrite;
  logic                  w_wordDone;
  logic [31:0]           w_stageNext;

  logic                  r_s1Valid;
  logic                  r_s1Last;
  logic signed [P_W-1:0] r_s1P;
  logic                  r_s2Valid;
  logic                  r_s2Last;
  logic [7:0]            r_s2Byte;
  logic [1:0]            r_laneCnt;
  logic [31:0]           r_stage;
  logic                  r_pkValid;
  logic [31:0]           r_pkData;
  logic [2:0]            r_pkBytes;
  logic [15:0]           r_satCnt;

  // The whole pipeline advances only when the output register is free or draining.
  assign w_en        = !r_pkValid || pk_ready_i;
  assign w_xfer      = acc_valid_i && w_en;
  assign acc_ready_o = w_en;

  assign w_sum  = $signed({acc_data_i[31], acc_data_i}) + $signed({bias_i[31], bias_i});
  assign w_prod = P_W'(w_sum) * P_W'(mult_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s1Valid <= 1'b0;
      r_s1Last  <= 1'b0;
      r_s1P     <= '0;
    end else if (w_en) begin
      r_s1Valid <= w_xfer;
      if (w_xfer) begin
        r_s1P    <= w_prod;
        r_s1Last <= acc_last_i;
      end
    end
  end

  // Round half up, then arithmetic shift; one extra bit keeps the rounding add exact.
  always_comb begin
    w_round = '0;
    if (shift_i != '0) w_round = R_W'(1) << (shift_i - SHIFT_W'(1));
    w_rnd = R_W'(r_s1P) + w_round;
    w_y   = w_rnd >>> shift_i;
  end

  always_comb begin
    w_byte = w_y[7:0];
    w_sat  = 1'b0;
`ifdef REQUANT_RELU_EN
    if (w_y[R_W-1]) begin
      w_byte = 8'h00;
    end else if (w_y > SAT_MAX) begin
      w_byte = 8'h7F;
      w_sat  = 1'b1;
    end
`else
    if (w_y > SAT_MAX) begin
      w_byte = 8'h7F;
      w_sat  = 1'b1;
    end else if (w_y < R_W'(-128)) begin
      w_byte = 8'h80;
      w_sat  = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s2Valid <= 1'b0;
      r_s2Last  <= 1'b0;
      r_s2Byte  <= '0;
    end else if (w_en) begin
      r_s2Valid <= r_s1Valid;
      r_s2Last  <= r_s1Last;
      r_s2Byte  <= w_byte;
    end
  end

  // Clear has priority; the counter sticks at all-ones.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_satCnt <= '0;
    end else if (sat_clr_i) begin
      r_satCnt <= '0;
    end else if (w_en && r_s1Valid && w_sat && (r_satCnt != 16'hFFFF)) begin
      r_satCnt <= r_satCnt + 16'd1;
    end
  end

  assign w_laneWrite = w_en && r_s2Valid;
  assign w_wordDone  = w_laneWrite && ((r_laneCnt == 2'd3) || r_s2Last);

  always_comb begin
    w_stageNext = r_stage;
    w_stageNext[{r_laneCnt, 3'b000} +: 8] = r_s2Byte;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_laneCnt <= '0;
      r_stage   <= '0;
      r_pkValid <= 1'b0;
      r_pkData  <= '0;
      r_pkBytes <= '0;
    end else begin
      if (w_laneWrite) begin
        if (w_wordDone) begin
          r_laneCnt <= '0;
          r_stage   <= '0;
        end else begin
          r_laneCnt <= r_laneCnt + 2'd1;
          r_stage   <= w_stageNext;
        end
      end
      if (w_en) r_pkValid <= w_wordDone;
      if (w_wordDone) begin
        r_pkData  <= w_stageNext;
        r_pkBytes <= {1'b0, r_laneCnt} + 3'd1;
      end
    end
  end

  assign pk_valid_o = r_pkValid;
  assign pk_data_o  = r_pkData;
  assign pk_bytes_o = r_pkBytes;
  assign sat_cnt_o  = r_satCnt;

endmodule

// File: tb/tb_mac_requant_packer.sv
// Self-checking bench for mac_requant_packer: directed table, corner sequences and a randomized
// run scored against an integer reference model of the requantize-and-pack rules.
module tb_mac_requant_packer;

  logic               clk = 1'b0;
  logic               rstN;
  logic               accValid;
  logic               accReady;
  logic signed [31:0] accData;
  logic               accLast;
  logic signed [31:0] bias;
  logic signed [15:0] mult;
  logic [4:0]         shift;
  logic               pkValid;
  logic               pkReady;
  logic [31:0]        pkData;
  logic [2:0]         pkBytes;
  logic [15:0]        satCnt;
  logic               satClr;

  int testsRun = 0;
  int failures = 0;
  bit modelOn = 0;
  bit randReady = 0;
  int modelSat = 0;
  int obsRead = 0;
  logic [7:0]  pendingB[$];
  logic [34:0] expectedQ[$];
  logic [34:0] observedQ[$];

  mac_requant_packer #(.MULT_W(16), .SHIFT_W(5)) dut (
    .clk_i(clk), .rst_ni(rstN),
    .acc_valid_i(accValid), .acc_ready_o(accReady), .acc_data_i(accData), .acc_last_i(accLast),
    .bias_i(bias), .mult_i(mult), .shift_i(shift),
    .pk_valid_o(pkValid), .pk_ready_i(pkReady), .pk_data_o(pkData), .pk_bytes_o(pkBytes),
    .sat_cnt_o(satCnt), .sat_clr_i(satClr)
  );

  always #5 clk = ~clk;

  // Records every word handed downstream, sampled half a cycle before the accepting edge.
  always @(negedge clk) begin
    if (rstN && pkValid && pkReady) observedQ.push_back({pkBytes, pkData});
  end

  typedef struct {
    logic signed [31:0] acc;
    logic signed [31:0] bias;
    logic signed [15:0] mult;
    logic [4:0]         shift;
    logic [7:0]         expByte;
    int                 expSat;
  } vec_t;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic timeoutFail(input string name);
    testsRun++;
    failures++;
    $display("[TB] FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (randReady) pkReady = ($urandom_range(0, 3) != 0);
  endtask

  function automatic logic [7:0] refByte(input longint a, input longint b, input longint m,
                                         input longint s, output bit sat);
    longint r;
    longint y;
    r = (a + b) * m;
    if (s > 0) r = r + (longint'(1) << (s - 1));
    y = r >>> s;
    sat = 0;
`ifdef REQUANT_RELU_EN
    if (y < 0) y = 0;
`endif
    if (y > 127) begin
      y = 127;
      sat = 1;
    end else if (y < -128) begin
      y = -128;
      sat = 1;
    end
    return y[7:0];
  endfunction

  task automatic applyStimulus(input logic signed [31:0] a, input logic l);
    int waited;
    bit satFlag;
    logic [7:0] b;
    logic [34:0] w;
    waited = 0;
    accData = a;
    accLast = l;
    accValid = 1'b1;
    @(negedge clk);
    while (!accReady && waited < 50) begin
      tick();
      @(negedge clk);
      waited++;
    end
    if (!accReady) begin
      timeoutFail("acceptTimeout");
    end else if (modelOn) begin
      b = refByte(longint'(a), longint'(bias), longint'(mult), longint'(shift), satFlag);
      if (satFlag && modelSat < 65535) modelSat++;
      pendingB.push_back(b);
      if (pendingB.size() == 4 || l) begin
        w = '0;
        foreach (pendingB[i]) w[8*i +: 8] = pendingB[i];
        w[34:32] = 3'(pendingB.size());
        expectedQ.push_back(w);
        pendingB.delete();
      end
    end
    tick();
    accValid = 1'b0;
    accLast = 1'b0;
  endtask

  task automatic drain();
    randReady = 0;
    pkReady = 1'b1;
    repeat (12) tick();
  endtask

  task automatic compareWords(input string tag);
    logic [34:0] e;
    logic [34:0] o;
    checkOutput({tag, ".wordCount"}, 64'(observedQ.size() - obsRead), 64'(expectedQ.size()));
    while (expectedQ.size() > 0 && obsRead < observedQ.size()) begin
      e = expectedQ.pop_front();
      o = observedQ[obsRead];
      obsRead++;
      checkOutput({tag, ".wordData"}, 64'(o[31:0]), 64'(e[31:0]));
      checkOutput({tag, ".wordBytes"}, 64'(o[34:32]), 64'(e[34:32]));
    end
    expectedQ.delete();
    obsRead = observedQ.size();
  endtask

  task automatic pulseSatClr();
    tick();
    satClr = 1'b1;
    tick();
    satClr = 1'b0;
    modelSat = 0;
  endtask

  initial begin
    vec_t vecs[$];
    int tableSat;
    int k;
    logic [34:0] o;
    int aVal;
    int bVal;
    bit lastFlag;

    rstN = 1'b0; accValid = 1'b0; accData = '0; accLast = 1'b0;
    bias = '0; mult = 16'sd1; shift = '0; pkReady = 1'b1; satClr = 1'b0;

    // Expected bytes differ only where a negative result would be clamped by the ReLU option.
`ifdef REQUANT_RELU_EN
    vecs = '{
      '{32'sd5, 32'sd0, 16'sd1, 5'd1, 8'h03, 0}, '{-32'sd5, 32'sd0, 16'sd1, 5'd1, 8'h00, 0},
      '{32'sd1000, 32'sd0, 16'sd1, 5'd0, 8'h7F, 1}, '{-32'sd1000, 32'sd0, 16'sd1, 5'd0, 8'h00, 0},
      '{32'sd100, 32'sd27, 16'sd1, 5'd0, 8'h7F, 0}, '{32'sd100, 32'sd28, 16'sd1, 5'd0, 8'h7F, 1},
      '{-32'sd128, 32'sd0, 16'sd1, 5'd0, 8'h00, 0}, '{-32'sd129, 32'sd0, 16'sd1, 5'd0, 8'h00, 0},
      '{32'sd7, 32'sd3, -16'sd2, 5'd2, 8'h00, 0}, '{32'h7FFFFFFF, 32'sd1, 16'sd1, 5'd25, 8'h40, 0},
      '{-32'sd3, 32'sd0, 16'sd1, 5'd1, 8'h00, 0}, '{32'sd3, 32'sd0, 16'sd1, 5'd1, 8'h02, 0},
      '{32'h7FFFFFFF, 32'h7FFFFFFF, 16'h7FFF, 5'd31, 8'h7F, 1},
      '{32'h80000000, 32'h80000000, -16'sd1, 5'd31, 8'h02, 0}};
`else
    vecs = '{
      '{32'sd5, 32'sd0, 16'sd1, 5'd1, 8'h03, 0}, '{-32'sd5, 32'sd0, 16'sd1, 5'd1, 8'hFE, 0},
      '{32'sd1000, 32'sd0, 16'sd1, 5'd0, 8'h7F, 1}, '{-32'sd1000, 32'sd0, 16'sd1, 5'd0, 8'h80, 1},
      '{32'sd100, 32'sd27, 16'sd1, 5'd0, 8'h7F, 0}, '{32'sd100, 32'sd28, 16'sd1, 5'd0, 8'h7F, 1},
      '{-32'sd128, 32'sd0, 16'sd1, 5'd0, 8'h80, 0}, '{-32'sd129, 32'sd0, 16'sd1, 5'd0, 8'h80, 1},
      '{32'sd7, 32'sd3, -16'sd2, 5'd2, 8'hFB, 0}, '{32'h7FFFFFFF, 32'sd1, 16'sd1, 5'd25, 8'h40, 0},
      '{-32'sd3, 32'sd0, 16'sd1, 5'd1, 8'hFF, 0}, '{32'sd3, 32'sd0, 16'sd1, 5'd1, 8'h02, 0},
      '{32'h7FFFFFFF, 32'h7FFFFFFF, 16'h7FFF, 5'd31, 8'h7F, 1},
      '{32'h80000000, 32'h80000000, -16'sd1, 5'd31, 8'h02, 0}};
`endif

    // Reset state.
    #12;
    checkOutput("reset.pkValid", 64'(pkValid), 64'd0);
    checkOutput("reset.pkData", 64'(pkData), 64'd0);
    checkOutput("reset.pkBytes", 64'(pkBytes), 64'd0);
    checkOutput("reset.satCnt", 64'(satCnt), 64'd0);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("reset.accReady", 64'(accReady), 64'd1);
    tick();

    // Four values make one full word two edges after the last accept.
    modelOn = 1;
    applyStimulus(32'sd1, 1'b0);
    applyStimulus(32'sd2, 1'b0);
    applyStimulus(32'sd3, 1'b0);
    applyStimulus(32'sd4, 1'b1);
    tick();
    checkOutput("latency.notYet", 64'(pkValid), 64'd0);
    tick();
    checkOutput("latency.valid", 64'(pkValid), 64'd1);
    checkOutput("latency.data", 64'(pkData), 64'h04030201);
    checkOutput("latency.bytes", 64'(pkBytes), 64'd4);
    drain();
    compareWords("basic");

    // Two saturating values closing a partial word.
    pulseSatClr();
    applyStimulus(32'sd1000, 1'b0);
    applyStimulus(-32'sd1000, 1'b1);
    drain();
    if (observedQ.size() > obsRead) begin
      o = observedQ[obsRead];
`ifdef REQUANT_RELU_EN
      checkOutput("satPair.data", 64'(o[31:0]), 64'h0000007F);
      checkOutput("satPair.satCnt", 64'(satCnt), 64'd1);
`else
      checkOutput("satPair.data", 64'(o[31:0]), 64'h0000807F);
      checkOutput("satPair.satCnt", 64'(satCnt), 64'd2);
`endif
      checkOutput("satPair.bytes", 64'(o[34:32]), 64'd2);
    end else begin
      timeoutFail("satPair.word");
    end
    compareWords("satPair");

    // Directed table: each vector is a single-lane word closed by last.
    modelOn = 0;
    pulseSatClr();
    tableSat = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      bias = vecs[i].bias;
      mult = vecs[i].mult;
      shift = vecs[i].shift;
      tableSat += vecs[i].expSat;
      applyStimulus(vecs[i].acc, 1'b1);
      k = 0;
      while (observedQ.size() <= obsRead && k < 20) begin
        tick();
        k++;
      end
      if (observedQ.size() > obsRead) begin
        o = observedQ[obsRead];
        obsRead++;
        checkOutput($sformatf("table[%0d].data", i), 64'(o[31:0]), {56'd0, vecs[i].expByte});
        checkOutput($sformatf("table[%0d].bytes", i), 64'(o[34:32]), 64'd1);
      end else begin
        timeoutFail($sformatf("table[%0d].word", i));
      end
    end
    drain();
    checkOutput("table.satCnt", 64'(satCnt), 64'(tableSat));
    obsRead = observedQ.size();

    // Downstream stall with eight values offered: the first word must sit stable while input is blocked.
    bias = '0; mult = 16'sd1; shift = '0;
    modelOn = 1;
    pulseSatClr();
    pkReady = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) applyStimulus(32'(i + 1), i == 7);
      end
      begin
        k = 0;
        while (!pkValid && k < 30) begin
          tick();
          k++;
        end
        if (!pkValid) timeoutFail("stall.firstWord");
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          checkOutput("stall.accReady", 64'(accReady), 64'd0);
          checkOutput("stall.data", 64'(pkData), 64'h04030201);
          checkOutput("stall.bytes", 64'(pkBytes), 64'd4);
          tick();
        end
        pkReady = 1'b1;
      end
    join
    drain();
    compareWords("stall");

    // Reset mid-vector discards the partial word.
    modelOn = 0;
    applyStimulus(32'sd17, 1'b0);
    applyStimulus(32'sd34, 1'b0);
    rstN = 1'b0;
    #2;
    checkOutput("midReset.pkValid", 64'(pkValid), 64'd0);
    checkOutput("midReset.satCnt", 64'(satCnt), 64'd0);
    @(negedge clk);
    rstN = 1'b1;
    drain();
    checkOutput("midReset.noWord", 64'(observedQ.size() - obsRead), 64'd0);
    obsRead = observedQ.size();
    modelOn = 1;
    modelSat = 0;
    pendingB.delete();
    for (int i = 0; i < 4; i++) applyStimulus(32'(10 * (i + 1)), 1'b0);
    drain();
    compareWords("afterReset");

    // Randomized batches with random backpressure; parameters change only between batches.
    for (int batch = 0; batch < 4; batch++) begin
      bias = 32'(int'($urandom_range(0, 1000)) - 500);
      mult = 16'(int'($urandom_range(0, 80)) - 40);
      shift = 5'($urandom_range(0, 10));
      randReady = 1;
      for (int i = 0; i < 50; i++) begin
        if ($urandom_range(0, 7) == 0) aVal = int'($urandom);
        else aVal = int'($urandom_range(0, 4000)) - 2000;
        lastFlag = ($urandom_range(0, 4) == 0) || (i == 49);
        applyStimulus(32'(aVal), lastFlag);
        if ($urandom_range(0, 3) == 0) tick();
      end
      drain();
      compareWords($sformatf("rnd%0d", batch));
      checkOutput($sformatf("rnd%0d.satCnt", batch), 64'(satCnt), 64'(modelSat));
    end

    // Saturation counter clear.
    bVal = modelSat;
    pulseSatClr();
    tick();
    checkOutput($sformatf("satClr.from%0d", bVal), 64'(satCnt), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
